// File: rtl/zh_pkg.sv
// Shared types and sizing helpers for the Zhegalkin (ANF) transform sequencer.
package zh_pkg;

  localparam int NVARS_MAX = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int zh_width(input int nvars);
    return 1 << nvars;
  endfunction

  // Stage counter width: enough bits to count 0..nvars-1, never less than one.
  function automatic int zh_sw(input int nvars);
    return (nvars <= 1) ? 1 : $clog2(nvars);
  endfunction

endpackage

// File: rtl/zh_stage.sv
// One butterfly stage of the ANF transform: stage k folds each entry whose
// index has bit k set with its partner that has bit k cleared.
module zh_stage
  import zh_pkg::*;
#(
  parameter  int NVARS = 5,
  localparam int WIDTH = zh_width(NVARS),
  localparam int SW    = zh_sw(NVARS)
) (
  input  logic [WIDTH-1:0] w,
  input  logic [SW-1:0]    k,
  output logic [WIDTH-1:0] w_next
);

  // Each stage index selects a fixed wiring pattern, so the loops unroll into
  // a WIDTH-wide mux in front of a single XOR plane.
  always_comb begin
    w_next = w;
    for (int kk = 0; kk < NVARS; kk++) begin
      if (k == SW'(kk)) begin
        for (int j = 0; j < WIDTH; j++) begin
          if (((j >> kk) & 1) == 1) begin
            w_next[j] = w[j] ^ w[j ^ (1 << kk)];
          end
        end
      end
    end
  end

endmodule

// File: rtl/zh_seq_ctrl.sv
// Multi-cycle ANF transform sequencer: accepts a truth table, applies one
// butterfly stage per enabled cycle, then offers the coefficient vector.
module zh_seq_ctrl
  import zh_pkg::*;
#(
  parameter  int NVARS = 5,
  localparam int WIDTH = zh_width(NVARS),
  localparam int SW    = zh_sw(NVARS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [SW-1:0]    stage
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. out_valid/out_data stay stable until out_ready; in_ready in DONE
  // mirrors out_ready so a new table can enter in the same cycle the old
  // result leaves.

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic [SW-1:0]    stage_q;
  logic [WIDTH-1:0] stage_out;

  localparam logic [SW-1:0] LAST_STAGE = SW'(NVARS - 1);

  zh_stage #(.NVARS(NVARS)) u_stage (
    .w      (data_q),
    .k      (stage_q),
    .w_next (stage_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      stage_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            stage_q <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (enable) begin
            data_q <= stage_out;
            if (stage_q == LAST_STAGE) begin
              stage_q <= '0;
              state_q <= DONE;
            end else begin
              stage_q <= stage_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              data_q  <= in_data;
              stage_q <= '0;
              state_q <= RUN;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          stage_q <= '0;
        end
      endcase
    end
  end

  // Output decode straight from the state register; in_ready is forced low
  // while reset is asserted so nothing is accepted during the reset cycle.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    case (state_q)
      IDLE: in_ready = !reset;
      RUN:  busy     = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        out_data  = data_q;
        in_ready  = out_ready && !reset;
      end
      default: ;
    endcase
  end

  assign stage = stage_q;

  a_stage_bound: assert property (@(posedge clk) disable iff (reset)
    stage_q <= LAST_STAGE);

  a_out_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_zh_seq_ctrl.sv
// Randomized self-checking bench for zh_seq_ctrl (NVARS=5) against a
// subset-sum (Moebius) model of the ANF transform.
module tb_zh_seq_ctrl;

  localparam int NVARS = 5;
  localparam int W     = 32;
  localparam int SW    = 3;
  localparam int BOUND = 200;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          busy;
  logic [SW-1:0] stage;

  logic [W-1:0]  exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  bit            en_pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  zh_seq_ctrl #(.NVARS(NVARS)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .stage     (stage)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Coefficient m is the XOR of f over every input j whose set bits are a subset of m.
  function automatic logic [W-1:0] ref_anf(input logic [W-1:0] t);
    logic [W-1:0] c;
    c = '0;
    for (int m = 0; m < W; m++)
      for (int j = 0; j < W; j++)
        if ((j & ~m) == 0) c[m] = c[m] ^ t[j];
    return c;
  endfunction

  // driver: wait for in_ready, hand over one table, push its expectation
  task automatic send(input logic [W-1:0] tbl);
    int waited;
    waited = 0;
    while (!in_ready && waited < BOUND) begin
      step();
      waited++;
    end
    check("in_ready_idle", W'(in_ready), W'(1));
    in_valid = 1'b1;
    in_data  = tbl;
    exp_q.push_back(ref_anf(tbl));
    step();
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  // mode 0: enable always high, 1: random enable, 2: fixed pattern
  task automatic finish(input int mode, input bit release_out, output logic [W-1:0] res);
    int cyc;
    int en_cnt;
    logic en;
    logic [W-1:0] exp;
    cyc = 0;
    en_cnt = 0;
    while (!out_valid && cyc < BOUND) begin
      check("busy_run", W'(busy), W'(1));
      check("stage_cnt", W'(stage), W'(en_cnt));
      check("zero_out", out_data, '0);
      case (mode)
        0:       en = 1'b1;
        1:       en = 1'($urandom_range(0, 1));
        default: en = en_pat[cyc % 7];
      endcase
      enable = en;
      step();
      cyc++;
      if (en) en_cnt++;
    end
    enable = 1'b1;
    check("done_valid", W'(out_valid), W'(1));
    check("en_cycles", W'(en_cnt), W'(NVARS));
    if (mode == 0) check("latency", W'(cyc), W'(NVARS));
    if (mode == 2) check("pat_cycles", W'(cyc), W'(7));
    check("busy_done", W'(busy), W'(0));
    check("stage_done", W'(stage), W'(0));
    res = out_data;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : ~out_data;
    check("anf", res, exp);
    if (release_out) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("to_idle_valid", W'(out_valid), W'(0));
      check("to_idle_ready", W'(in_ready), W'(1));
    end
  endtask

  task automatic xact(input logic [W-1:0] tbl, input int mode, output logic [W-1:0] res);
    send(tbl);
    finish(mode, 1'b1, res);
  endtask

  initial begin
    logic [W-1:0] r;
    logic [W-1:0] r2;
    logic [W-1:0] t;
    logic [W-1:0] tbls[4];
    logic [W-1:0] exps[4];
    tbls = '{32'h0000_0001, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h8000_0000};
    exps = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0002, 32'h8000_0000};

    // reset state
    #1;
    check("rst_in_ready", W'(in_ready), W'(0));
    step();
    step();
    check("rst_valid", W'(out_valid), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_stage", W'(stage), W'(0));
    check("rst_data", out_data, '0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", W'(in_ready), W'(1));

    // directed tables
    for (int i = 0; i < 4; i++) begin
      xact(tbls[i], 0, r);
      check("directed", r, exps[i]);
    end

    // enable gating pattern 1,0,0,1,1,1,1
    xact(32'h0000_0001, 2, r);
    check("pattern_res", r, 32'hFFFF_FFFF);

    // output backpressure then back-to-back accept
    send(32'h0000_0001);
    finish(0, 1'b0, r);
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b0;
      step();
      check("hold_valid", W'(out_valid), W'(1));
      check("hold_data", out_data, 32'hFFFF_FFFF);
      check("hold_in_ready", W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hFFFF_FFFF;
    #1;
    check("b2b_in_ready", W'(in_ready), W'(1));
    exp_q.push_back(ref_anf(32'hFFFF_FFFF));
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_busy", W'(busy), W'(1));
    check("b2b_valid", W'(out_valid), W'(0));
    finish(0, 1'b1, r);
    check("b2b_res", r, 32'h0000_0001);

    // reset in the middle of RUN
    send(32'h1234_5678);
    enable = 1'b1;
    step();
    step();
    check("mid_stage", W'(stage), W'(2));
    reset = 1'b1;
    step();
    check("mr_valid", W'(out_valid), W'(0));
    check("mr_busy", W'(busy), W'(0));
    check("mr_stage", W'(stage), W'(0));
    check("mr_in_ready", W'(in_ready), W'(0));
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("mr_idle_ready", W'(in_ready), W'(1));
    xact(32'hAAAA_AAAA, 0, r);
    check("mr_fresh", r, 32'h0000_0002);

    // random involution
    for (int i = 0; i < 200; i++) begin
      t = $urandom;
      xact(t, (i % 2 == 0) ? 0 : 1, r);
      xact(r, 1, r2);
      check("involution", r2, t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
